// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared geometry, mode encodings and colour constants for the VGA pixel pipe
package vga_pkg;

  localparam int H_ACTIVE  = 800;
  localparam int V_ACTIVE  = 600;
  localparam int BOX_SIZE  = 32;
  localparam int BOX_X_MAX = H_ACTIVE - BOX_SIZE;
  localparam int BOX_Y_MAX = V_ACTIVE - BOX_SIZE;

  typedef enum logic [1:0] {
    MODE_WHITE   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_BOX     = 2'd3
  } mode_e;

  localparam logic [2:0] RGB_BLACK = 3'b000;
  localparam logic [2:0] RGB_WHITE = 3'b111;
  localparam logic [2:0] RGB_RED   = 3'b100;

endpackage

// File: rtl/vga_box_mover.sv
// rtl/vga_box_mover.sv - bouncing box position, stepped once per frame
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int STEP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  output logic [9:0] box_x,
  output logic [9:0] box_y
);

  localparam logic [9:0] STEP_W = 10'(STEP);
  localparam logic [9:0] X_MAX  = 10'(BOX_X_MAX);
  localparam logic [9:0] Y_MAX  = 10'(BOX_Y_MAX);

  logic [9:0] r_box_x;
  logic [9:0] r_box_y;
  logic       r_x_neg;
  logic       r_y_neg;

  // Horizontal bounce: reverse on reaching either edge, otherwise keep moving.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_box_x <= '0;
      r_x_neg <= 1'b0;
    end else if (frame_start) begin
      if (!r_x_neg && r_box_x == X_MAX) begin
        r_x_neg <= 1'b1;
        r_box_x <= X_MAX - STEP_W;
      end else if (r_x_neg && r_box_x == '0) begin
        r_x_neg <= 1'b0;
        r_box_x <= STEP_W;
      end else if (r_x_neg) begin
        r_box_x <= r_box_x - STEP_W;
      end else begin
        r_box_x <= r_box_x + STEP_W;
      end
    end
  end

  // Vertical bounce: same rule as horizontal with the shorter bound.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_box_y <= '0;
      r_y_neg <= 1'b0;
    end else if (frame_start) begin
      if (!r_y_neg && r_box_y == Y_MAX) begin
        r_y_neg <= 1'b1;
        r_box_y <= Y_MAX - STEP_W;
      end else if (r_y_neg && r_box_y == '0) begin
        r_y_neg <= 1'b0;
        r_box_y <= STEP_W;
      end else if (r_y_neg) begin
        r_box_y <= r_box_y - STEP_W;
      end else begin
        r_box_y <= r_box_y + STEP_W;
      end
    end
  end

  assign box_x = r_box_x;
  assign box_y = r_box_y;

endmodule

// File: rtl/vga_pixel_pipe.sv
// rtl/vga_pixel_pipe.sv - two-stage pattern generator; VGA_BORDER_EN adds a white frame border
module vga_pixel_pipe
  import vga_pkg::*;
#(
  parameter int H_ACT_START = 143,
  parameter int V_ACT_START = 29,
  parameter int STEP        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [1:0] mode,
  output logic [2:0] disp_RGB,
  output logic       hsync,
  output logic       vsync
);

  localparam logic [10:0] H_LO = 11'(H_ACT_START);
  localparam logic [10:0] H_HI = 11'(H_ACT_START + H_ACTIVE - 1);
  localparam logic [10:0] V_LO = 11'(V_ACT_START);
  localparam logic [10:0] V_HI = 11'(V_ACT_START + V_ACTIVE - 1);

  logic        w_frame_start;
  logic        w_active;
  logic [9:0]  w_x;
  logic [9:0]  w_y;
  logic [9:0]  w_box_x;
  logic [9:0]  w_box_y;
  logic        w_in_box;
  logic [2:0]  w_rgb;

  logic        r_s1_active;
  logic [9:0]  r_s1_x;
  logic [9:0]  r_s1_y;
  logic        r_s1_hs;
  logic        r_s1_vs;
  logic [2:0]  r_rgb;
  logic        r_hs;
  logic        r_vs;
  mode_e       r_mode_q;

  assign w_frame_start = pix_en && (hcount == '0) && (vcount == '0);
  assign w_active = ({1'b0, hcount} >= H_LO) && ({1'b0, hcount} <= H_HI) &&
                    ({1'b0, vcount} >= V_LO) && ({1'b0, vcount} <= V_HI);
  assign w_x = hcount - 10'(H_ACT_START);
  assign w_y = vcount - 10'(V_ACT_START);

  vga_box_mover #(
    .STEP (STEP)
  ) u_box_mover (
    .clk         (clk),
    .rst         (rst),
    .frame_start (w_frame_start),
    .box_x       (w_box_x),
    .box_y       (w_box_y)
  );

  // Mode only changes at the top of a frame so a picture is never split between patterns.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_q <= MODE_WHITE;
    end else if (w_frame_start) begin
      r_mode_q <= mode_e'(mode);
    end
  end

  // Stage 1: register the active flag, pixel coordinates and raw syncs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_active <= 1'b0;
      r_s1_x      <= '0;
      r_s1_y      <= '0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
    end else if (pix_en) begin
      r_s1_active <= w_active;
      r_s1_x      <= w_x;
      r_s1_y      <= w_y;
      r_s1_hs     <= hsync_in;
      r_s1_vs     <= vsync_in;
    end
  end

  assign w_in_box = ({1'b0, r_s1_x} >= {1'b0, w_box_x}) &&
                    ({1'b0, r_s1_x} <  ({1'b0, w_box_x} + 11'(BOX_SIZE))) &&
                    ({1'b0, r_s1_y} >= {1'b0, w_box_y}) &&
                    ({1'b0, r_s1_y} <  ({1'b0, w_box_y} + 11'(BOX_SIZE)));

  // Pattern colour for the stage-1 pixel; blanking forces black.
  always_comb begin
    w_rgb = RGB_BLACK;
    if (r_s1_active) begin
      case (r_mode_q)
        MODE_WHITE:   w_rgb = RGB_WHITE;
        MODE_BARS:    w_rgb = r_s1_x[9:7];
        MODE_CHECKER: w_rgb = (r_s1_x[5] ^ r_s1_y[5]) ? RGB_WHITE : RGB_BLACK;
        MODE_BOX:     w_rgb = w_in_box ? RGB_RED : RGB_BLACK;
        default:      w_rgb = RGB_BLACK;
      endcase
`ifdef VGA_BORDER_EN
      if ((r_s1_x == '0) || (r_s1_x == 10'(H_ACTIVE - 1)) ||
          (r_s1_y == '0) || (r_s1_y == 10'(V_ACTIVE - 1))) begin
        w_rgb = RGB_WHITE;
      end
`endif
    end
  end

  // Stage 2: register colour and syncs together so they leave the block aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb <= RGB_BLACK;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
    end else if (pix_en) begin
      r_rgb <= w_rgb;
      r_hs  <= r_s1_hs;
      r_vs  <= r_s1_vs;
    end
  end

  assign disp_RGB = r_rgb;
  assign hsync    = r_hs;
  assign vsync    = r_vs;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// tb/tb_vga_pixel_pipe.sv - directed self-checking bench for vga_pixel_pipe
module tb_vga_pixel_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_en;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync_in;
  logic       vsync_in;
  logic [1:0] mode;
  logic [2:0] disp_RGB;
  logic       hsync;
  logic       vsync;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_pixel_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .pix_en   (pix_en),
    .hcount   (hcount),
    .vcount   (vcount),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .mode     (mode),
    .disp_RGB (disp_RGB),
    .hsync    (hsync),
    .vsync    (vsync)
  );

  typedef struct {
    logic [1:0] mode;
    logic [9:0] h;
    logic [9:0] v;
    logic [2:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [2:0] bexp(input int h, input int v, input logic [2:0] base);
    bexp = base;
`ifdef VGA_BORDER_EN
    if (h >= 143 && h <= 942 && v >= 29 && v <= 628 &&
        (h == 143 || h == 942 || v == 29 || v == 628)) bexp = 3'b111;
`endif
  endfunction

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Entered and left on a negedge; one pix_en pulse then three idle clocks.
  task automatic strobe(input int h, input int v, input logic hs, input logic vs);
    hcount   = 10'(h);
    vcount   = 10'(v);
    hsync_in = hs;
    vsync_in = vs;
    pix_en   = 1'b1;
    @(negedge clk);
    pix_en   = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame();
    strobe(0, 0, 1'b0, 1'b0);
  endtask

  task automatic probe(input string name, input int h, input int v, input logic [2:0] base);
    strobe(h, v, 1'b0, 1'b0);
    strobe(5, 5, 1'b0, 1'b0);
    check3(name, disp_RGB, bexp(h, v, base));
  endtask

  logic hs_prev, vs_prev, hs_cur, vs_cur;
  int   hs_width;

  initial begin
    vecs[0]  = '{2'd0, 10'd143, 10'd29,  3'b111, "white_first"};
    vecs[1]  = '{2'd0, 10'd142, 10'd29,  3'b000, "white_h142"};
    vecs[2]  = '{2'd0, 10'd143, 10'd28,  3'b000, "white_v28"};
    vecs[3]  = '{2'd0, 10'd942, 10'd628, 3'b111, "white_last"};
    vecs[4]  = '{2'd0, 10'd943, 10'd29,  3'b000, "white_h943"};
    vecs[5]  = '{2'd0, 10'd143, 10'd629, 3'b000, "white_v629"};
    vecs[6]  = '{2'd1, 10'd443, 10'd100, 3'b010, "bars_x300"};
    vecs[7]  = '{2'd1, 10'd942, 10'd100, 3'b110, "bars_x799"};
    vecs[8]  = '{2'd1, 10'd911, 10'd100, 3'b110, "bars_x768"};
    vecs[9]  = '{2'd1, 10'd910, 10'd100, 3'b101, "bars_x767"};
    vecs[10] = '{2'd1, 10'd142, 10'd100, 3'b000, "bars_blank"};
    vecs[11] = '{2'd2, 10'd175, 10'd29,  3'b111, "chk_x32_y0"};
    vecs[12] = '{2'd2, 10'd175, 10'd61,  3'b000, "chk_x32_y32"};
    vecs[13] = '{2'd2, 10'd143, 10'd61,  3'b111, "chk_x0_y32"};
    vecs[14] = '{2'd2, 10'd174, 10'd60,  3'b000, "chk_x31_y31"};
    vecs[15] = '{2'd2, 10'd207, 10'd29,  3'b000, "chk_x64_y0"};

    rst = 1'b1; pix_en = 1'b0; hcount = '0; vcount = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; mode = 2'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check3("reset_rgb", disp_RGB, 3'b000);
    check1("reset_hsync", hsync, 1'b0);
    check1("reset_vsync", vsync, 1'b0);

    // First strobe after reset shifts out the zeroed stage 1.
    strobe(143, 29, 1'b1, 1'b1);
    check3("post_reset_rgb", disp_RGB, 3'b000);
    check1("post_reset_hsync", hsync, 1'b0);

    for (int i = 0; i < 16; i++) begin
      mode = vecs[i].mode;
      frame();
      probe(vecs[i].name, int'(vecs[i].h), int'(vecs[i].v), vecs[i].exp);
    end

    // Mode change mid-frame is deferred to the next frame start.
    mode = 2'd0;
    frame();
    mode = 2'd2;
    probe("midframe_still_white", 175, 329, 3'b111);
    frame();
    probe("nextframe_checker", 175, 329, 3'b000);

    // Sync pass-through: 95-strobe hsync pulse, 2-strobe vsync pulse.
    strobe(1000, 700, 1'b0, 1'b0);
    hs_prev = 1'b0; vs_prev = 1'b0; hs_width = 0;
    for (int k = 0; k < 120; k++) begin
      hs_cur = (k >= 5 && k < 100);
      vs_cur = (k >= 10 && k < 12);
      strobe(1000, 700, hs_cur, vs_cur);
      check1($sformatf("hsync_k%0d", k), hsync, hs_prev);
      check1($sformatf("vsync_k%0d", k), vsync, vs_prev);
      if (hsync) hs_width++;
      hs_prev = hs_cur;
      vs_prev = vs_cur;
    end
    checks++;
    if (hs_width != 95) begin
      failures++;
      $display("FAIL hsync_width actual=%0d expected=95", hs_width);
    end

    // Freeze: with pix_en low, outputs hold regardless of inputs.
    mode = 2'd0;
    frame();
    strobe(143, 29, 1'b1, 1'b0);
    strobe(5, 5, 1'b0, 1'b1);
    check3("freeze_setup_rgb", disp_RGB, bexp(143, 29, 3'b111));
    for (int c = 0; c < 12; c++) begin
      hcount = 10'($urandom_range(0, 1023));
      vcount = 10'($urandom_range(0, 1023));
      hsync_in = ~hsync_in;
      vsync_in = ~vsync_in;
      @(negedge clk);
      check3($sformatf("freeze_rgb_%0d", c), disp_RGB, bexp(143, 29, 3'b111));
      check1($sformatf("freeze_hs_%0d", c), hsync, 1'b1);
      check1($sformatf("freeze_vs_%0d", c), vsync, 1'b0);
    end

    // Reset mid-frame wins over a coincident strobe.
    strobe(143, 29, 1'b1, 1'b1);
    hcount = 10'd143; vcount = 10'd29; hsync_in = 1'b1; vsync_in = 1'b1;
    rst = 1'b1; pix_en = 1'b1;
    @(negedge clk);
    rst = 1'b0; pix_en = 1'b0;
    check3("midreset_rgb", disp_RGB, 3'b000);
    check1("midreset_hsync", hsync, 1'b0);
    check1("midreset_vsync", vsync, 1'b0);
    repeat (3) @(negedge clk);

    // Box motion from reset: frame n puts the box at 2n until the bounds.
    mode = 2'd3;
    for (int n = 1; n <= 385; n++) begin
      frame();
      if (n == 1) begin
        probe("box1_in",    145, 31, 3'b100);
        probe("box1_left",  144, 31, 3'b000);
        probe("box1_above", 145, 30, 3'b000);
      end else if (n == 284) begin
        probe("box284_in",    711, 597, 3'b100);
        probe("box284_left",  710, 597, 3'b000);
        probe("box284_above", 711, 596, 3'b000);
      end else if (n == 285) begin
        probe("box285_in",     713, 595, 3'b100);
        probe("box285_above",  713, 594, 3'b000);
        probe("box285_bottom", 713, 626, 3'b100);
        probe("box285_below",  713, 627, 3'b000);
      end else if (n == 384) begin
        probe("box384_in",    911, 397, 3'b100);
        probe("box384_left",  910, 397, 3'b000);
        probe("box384_right", 942, 397, 3'b100);
      end else if (n == 385) begin
        probe("box385_in",     909, 395, 3'b100);
        probe("box385_past",   941, 395, 3'b000);
        probe("box385_right",  940, 395, 3'b100);
        probe("box385_above",  909, 394, 3'b000);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
